axi_native_slave_mem: RTL
=========================

Name: axi_native_slave_mem

Overview:
- AXI4 full-protocol memory responder that terminates the write and read channels driven by the fifo2axi-style native masters.
- Backed by an internal byte-enable RAM; single clock domain.
- Used as a DDR/PCIe stand-in for bring-up, loopback and bench closure of the master path.
- Write and read channels run independently and may be active in the same cycle.

Parameters:
- DATA_WDTH, 32, data bus width in bits (32/64/128/256).
- ADDR_WDTH, 32, byte address width.
- MEM_DPTH, 1024, RAM depth in DATA_WDTH words; power of two.
- BASE_ADDR, 0, byte address of word 0; aligned to MEM_DPTH*DATA_WDTH/8.
- DGBCNT_WDTH, 16, width of the debug counters.

Ports:
- axi_clk  in  1  single clock.
- axi_rst_n  in  1  asynchronous, active-low reset.
- s_axi_awaddr  in  ADDR_WDTH  write start byte address.
- s_axi_awlen  in  8  beats-1.
- s_axi_awid  in  4  write ID.
- s_axi_awburst/awsize/awcache/awlock/awprot/awqos/awuser  in  2/3/4/1/3/4/1  accepted and ignored.
- s_axi_awvalid  in  1 ; s_axi_awready  out  1.
- s_axi_wdata  in  DATA_WDTH ; s_axi_wstrb  in  DATA_WDTH/8 ; s_axi_wlast  in  1.
- s_axi_wvalid  in  1 ; s_axi_wready  out  1.
- s_axi_bid  out  4 ; s_axi_bresp  out  2 ; s_axi_bvalid  out  1 ; s_axi_bready  in  1.
- s_axi_araddr  in  ADDR_WDTH ; s_axi_arlen  in  8 ; s_axi_arid  in  4.
- s_axi_arburst/arsize/arcache/arlock/arprot/arqos/aruser  in  (as AW)  ignored.
- s_axi_arvalid  in  1 ; s_axi_arready  out  1.
- s_axi_rdata  out  DATA_WDTH ; s_axi_rresp  out  2 ; s_axi_rid  out  4 ; s_axi_rlast  out  1.
- s_axi_rvalid  out  1 ; s_axi_rready  in  1.
- dbg_cnt_clr  in  1  synchronous clear of the debug counters.
- dbg_aw_cnt, dbg_ar_cnt, dbg_err_cnt  out  DGBCNT_WDTH  debug counters (see Optional Feature).

Behaviour:
- Reset values:
  - awready=1, arready=1.
  - wready=0, bvalid=0, rvalid=0, rlast=0.
  - bresp/rresp=0, bid/rid=0, rdata=0.
  - Counters 0; both FSMs idle.
  - RAM contents are not reset.
- Addressing:
  - word = (addr - BASE_ADDR) >> log2(DATA_WDTH/8).
  - Burst is always treated as INCR; the low byte-offset bits are ignored.
  - Error condition: addr < BASE_ADDR, or word + len > MEM_DPTH-1. The test is computed with 1 bit of headroom so it cannot wrap.
  - An error flags the whole burst as SLVERR (2'b10); otherwise OKAY (2'b00).
- Write FSM:
  - W_IDLE: awready=1. On awvalid&awready, latch id, word, len and err; awready→0; wready→1 next cycle; go to W_DATA.
  - W_DATA: each wvalid&wready writes wstrb-enabled bytes to RAM[word] unless err is set, then word+1 and beat counter+1.
    - wlast is ignored for termination; the beat counter reaching len ends the burst.
    - wlast mismatch (early or missing) sets the err latch, so the response is SLVERR.
    - On the final beat: wready→0, bvalid→1, go to W_RESP.
  - W_RESP: hold bvalid, bid and bresp until bready. Then bvalid→0, awready→1, go to W_IDLE.
  - Minimum turnaround: 1 cycle per beat plus 2 cycles overhead.
- Read FSM:
  - R_IDLE: arready=1. On accept, latch id, word, len and err; arready→0; go to R_DATA.
  - R_DATA: first rvalid appears 1 cycle after AR accept (registered RAM read).
    - rdata is loaded when !rvalid | rready.
    - rdata=0 when err is set.
    - rlast=1 on beat len.
    - Full throughput (1 beat/cycle) under continuous rready.
    - rvalid, rdata, rlast, rresp and rid hold stable while rready=0.
  - After the last beat handshake: rvalid→0, arready→1 in the same cycle, go to R_IDLE.
- Simultaneous write and read to the same word in the same cycle: the read returns old data (read-first).
- AXI rule: valid is never deasserted before its handshake, and is never made dependent on ready.
- Mid-burst reset: all outputs return to reset values asynchronously; partially written data remains in RAM.

Optional Feature:
- Macro: AXI_SLV_DBGCNT_EN.
- With the macro defined:
  - dbg_aw_cnt counts AW handshakes.
  - dbg_ar_cnt counts AR handshakes.
  - dbg_err_cnt counts SLVERR responses (B and last-R).
  - Counters saturate at all-ones and clear on dbg_cnt_clr; dbg_cnt_clr wins over a simultaneous increment.
- Without the macro: the counter outputs are tied to 0 and no counter flops are generated.

Decomposition:
- Package axi_slv_pkg:
  - Response constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - Write-state typedef {W_IDLE, W_DATA, W_RESP}.
  - Read-state typedef {R_IDLE, R_DATA}.
  - Function clog2.
- One sub-module, axi_slv_ram: simple dual-port RAM, one write port with byte enables, one registered read port with read enable, read-first behaviour.

Test Plan:
- Write awaddr=0x10, awlen=3, data 0xA0..0xA3, wstrb=0xF → bresp=0, bid echoed. Then read araddr=0x10, arlen=3 → rdata A0,A1,A2,A3; rlast only on the 4th beat; rresp=0.
- Write word 0=0x11223344, then write word 0 with wstrb=0x2 and data 0xFFFFFFFF → readback 0x1122FF44.
- MEM_DPTH=1024: awaddr=0xFFC, awlen=1 → bresp=2'b10 and RAM unchanged. araddr=0xFFC, arlen=0 → rresp=0 with valid data.
- Read arlen=7 with rready toggled 1/0 every cycle → 8 beats, no lost or duplicated beat, outputs stable during rready=0.
- Concurrent AW/W burst (len=15) and AR burst (len=15) to disjoint regions with bready held 0 for 5 cycles → both complete, reads unaffected, bvalid held.
- Assert axi_rst_n low at read beat 2 of 8 → rvalid=0 immediately; after release arready=1 and a new burst completes normally.

Source files
------------

// File: rtl/axi_slv_pkg.sv
// Shared types, response codes and helpers for the AXI memory responder.
package axi_slv_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
   typedef enum logic       {R_IDLE, R_DATA}         rstate_e;

   // Ceiling log2 for parameter arithmetic.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) r++;
      return r;
   endfunction

endpackage

// File: rtl/axi_slv_ram.sv
// Simple dual-port RAM: byte-enable write port, registered read port (read-first).
module axi_slv_ram
   import axi_slv_pkg::*;
#(
   parameter int unsigned DATA_WDTH = 32,
   parameter int unsigned MEM_DPTH  = 1024,
   localparam int unsigned AW = clog2(MEM_DPTH),
   localparam int unsigned NB = DATA_WDTH / 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 we_i,
   input  logic [AW-1:0]        waddr_i,
   input  logic [NB-1:0]        wstrb_i,
   input  logic [DATA_WDTH-1:0] wdata_i,
   input  logic                 re_i,
   input  logic                 rzero_i,
   input  logic [AW-1:0]        raddr_i,
   output logic [DATA_WDTH-1:0] rdata_o
);

   logic [DATA_WDTH-1:0] mem_q [MEM_DPTH];
   logic [DATA_WDTH-1:0] rdata_q;

   // Byte-enabled write; storage is never reset.
   always_ff @(posedge clk) begin
      if (we_i) begin
         for (int b = 0; b < int'(NB); b++) begin
            if (wstrb_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
         end
      end
   end

   // Registered read; old contents win on a same-cycle write, rzero_i forces zero data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    rdata_q <= '0;
      else if (re_i) rdata_q <= rzero_i ? '0 : mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_native_slave_mem.sv
// AXI4 memory responder with independent write/read FSMs over an internal RAM.
// Optional debug counters: define AXI_SLV_DBGCNT_EN.
module axi_native_slave_mem
   import axi_slv_pkg::*;
#(
   parameter int unsigned          DATA_WDTH   = 32,
   parameter int unsigned          ADDR_WDTH   = 32,
   parameter int unsigned          MEM_DPTH    = 1024,
   parameter logic [ADDR_WDTH-1:0] BASE_ADDR   = '0,
   parameter int unsigned          DGBCNT_WDTH = 16
) (
   input  logic                   axi_clk,
   input  logic                   axi_rst_n,
   input  logic [ADDR_WDTH-1:0]   s_axi_awaddr,
   input  logic [7:0]             s_axi_awlen,
   input  logic [3:0]             s_axi_awid,
   input  logic [1:0]             s_axi_awburst,
   input  logic [2:0]             s_axi_awsize,
   input  logic [3:0]             s_axi_awcache,
   input  logic                   s_axi_awlock,
   input  logic [2:0]             s_axi_awprot,
   input  logic [3:0]             s_axi_awqos,
   input  logic                   s_axi_awuser,
   input  logic                   s_axi_awvalid,
   output logic                   s_axi_awready,
   input  logic [DATA_WDTH-1:0]   s_axi_wdata,
   input  logic [DATA_WDTH/8-1:0] s_axi_wstrb,
   input  logic                   s_axi_wlast,
   input  logic                   s_axi_wvalid,
   output logic                   s_axi_wready,
   output logic [3:0]             s_axi_bid,
   output logic [1:0]             s_axi_bresp,
   output logic                   s_axi_bvalid,
   input  logic                   s_axi_bready,
   input  logic [ADDR_WDTH-1:0]   s_axi_araddr,
   input  logic [7:0]             s_axi_arlen,
   input  logic [3:0]             s_axi_arid,
   input  logic [1:0]             s_axi_arburst,
   input  logic [2:0]             s_axi_arsize,
   input  logic [3:0]             s_axi_arcache,
   input  logic                   s_axi_arlock,
   input  logic [2:0]             s_axi_arprot,
   input  logic [3:0]             s_axi_arqos,
   input  logic                   s_axi_aruser,
   input  logic                   s_axi_arvalid,
   output logic                   s_axi_arready,
   output logic [DATA_WDTH-1:0]   s_axi_rdata,
   output logic [1:0]             s_axi_rresp,
   output logic [3:0]             s_axi_rid,
   output logic                   s_axi_rlast,
   output logic                   s_axi_rvalid,
   input  logic                   s_axi_rready,
   input  logic                   dbg_cnt_clr,
   output logic [DGBCNT_WDTH-1:0] dbg_aw_cnt,
   output logic [DGBCNT_WDTH-1:0] dbg_ar_cnt,
   output logic [DGBCNT_WDTH-1:0] dbg_err_cnt
);

   localparam int unsigned SH = clog2(DATA_WDTH / 8);
   localparam int unsigned MW = clog2(MEM_DPTH);
   localparam int unsigned XW = ADDR_WDTH + 1;

   // Word index relative to BASE_ADDR, one bit wider so the range test cannot wrap.
   function automatic logic [XW-1:0] word_of(input logic [ADDR_WDTH-1:0] a);
      return XW'((a - BASE_ADDR) >> SH);
   endfunction

   function automatic logic err_of(input logic [ADDR_WDTH-1:0] a, input logic [7:0] len);
      return (a < BASE_ADDR) || ((word_of(a) + XW'(len)) > XW'(MEM_DPTH - 1));
   endfunction

   wstate_e         wstate_q, wstate_d;
   logic            awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
   logic [1:0]      bresp_q, bresp_d;
   logic [3:0]      bid_q, bid_d;
   logic [MW-1:0]   wword_q, wword_d;
   logic [7:0]      wlen_q, wlen_d, wbeat_q, wbeat_d;
   logic            werr_q, werr_d;
   logic            ram_we, wlast_exp;

   rstate_e         rstate_q, rstate_d;
   logic            arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
   logic [1:0]      rresp_q, rresp_d;
   logic [3:0]      rid_q, rid_d;
   logic [MW-1:0]   rword_q, rword_d;
   logic [7:0]      rlen_q, rlen_d, rcnt_q, rcnt_d;
   logic            ram_re, ram_rzero;
   logic [MW-1:0]   ram_raddr;

   // Write and read channel state registers.
   always_ff @(posedge axi_clk or negedge axi_rst_n) begin
      if (!axi_rst_n) begin
         wstate_q <= W_IDLE;  awready_q <= 1'b1; wready_q <= 1'b0; bvalid_q <= 1'b0;
         bresp_q  <= RESP_OKAY; bid_q <= '0; wword_q <= '0; wlen_q <= '0; wbeat_q <= '0;
         werr_q   <= 1'b0;
         rstate_q <= R_IDLE;  arready_q <= 1'b1; rvalid_q <= 1'b0; rlast_q <= 1'b0;
         rresp_q  <= RESP_OKAY; rid_q <= '0; rword_q <= '0; rlen_q <= '0; rcnt_q <= '0;
      end else begin
         wstate_q <= wstate_d; awready_q <= awready_d; wready_q <= wready_d; bvalid_q <= bvalid_d;
         bresp_q  <= bresp_d;  bid_q <= bid_d; wword_q <= wword_d; wlen_q <= wlen_d; wbeat_q <= wbeat_d;
         werr_q   <= werr_d;
         rstate_q <= rstate_d; arready_q <= arready_d; rvalid_q <= rvalid_d; rlast_q <= rlast_d;
         rresp_q  <= rresp_d;  rid_q <= rid_d; rword_q <= rword_d; rlen_q <= rlen_d; rcnt_q <= rcnt_d;
      end
   end

   // Write FSM: the beat count, not wlast, terminates the burst; a wlast mismatch poisons the response.
   always_comb begin
      wstate_d  = wstate_q;  awready_d = awready_q; wready_d = wready_q; bvalid_d = bvalid_q;
      bresp_d   = bresp_q;   bid_d     = bid_q;     wword_d  = wword_q;  wlen_d   = wlen_q;
      wbeat_d   = wbeat_q;   werr_d    = werr_q;    ram_we   = 1'b0;
      wlast_exp = (wbeat_q == wlen_q);
      unique case (wstate_q)
         W_IDLE: begin
            if (s_axi_awvalid && awready_q) begin
               bid_d     = s_axi_awid;
               wword_d   = MW'(word_of(s_axi_awaddr));
               wlen_d    = s_axi_awlen;
               wbeat_d   = '0;
               werr_d    = err_of(s_axi_awaddr, s_axi_awlen);
               awready_d = 1'b0;
               wready_d  = 1'b1;
               wstate_d  = W_DATA;
            end
         end
         W_DATA: begin
            if (s_axi_wvalid && wready_q) begin
               ram_we  = !werr_q;
               wword_d = wword_q + MW'(1);
               wbeat_d = wbeat_q + 8'd1;
               if (s_axi_wlast != wlast_exp) werr_d = 1'b1;
               if (wlast_exp) begin
                  wready_d = 1'b0;
                  bvalid_d = 1'b1;
                  bresp_d  = (werr_q || (s_axi_wlast != wlast_exp)) ? RESP_SLVERR : RESP_OKAY;
                  wstate_d = W_RESP;
               end
            end
         end
         W_RESP: begin
            if (s_axi_bready) begin
               bvalid_d  = 1'b0;
               awready_d = 1'b1;
               wstate_d  = W_IDLE;
            end
         end
         default: wstate_d = W_IDLE;
      endcase
   end

   // Read FSM: RAM read issued on AR accept and on each accepted beat, giving one beat per cycle.
   always_comb begin
      rstate_d  = rstate_q; arready_d = arready_q; rvalid_d = rvalid_q; rlast_d = rlast_q;
      rresp_d   = rresp_q;  rid_d     = rid_q;     rword_d  = rword_q;  rlen_d  = rlen_q;
      rcnt_d    = rcnt_q;
      ram_re    = 1'b0;     ram_raddr = rword_q;   ram_rzero = rerr_of_resp(rresp_q);
      unique case (rstate_q)
         R_IDLE: begin
            if (s_axi_arvalid && arready_q) begin
               ram_re    = 1'b1;
               ram_raddr = MW'(word_of(s_axi_araddr));
               ram_rzero = err_of(s_axi_araddr, s_axi_arlen);
               rresp_d   = ram_rzero ? RESP_SLVERR : RESP_OKAY;
               rid_d     = s_axi_arid;
               rlen_d    = s_axi_arlen;
               rword_d   = ram_raddr + MW'(1);
               rcnt_d    = 8'd1;
               rlast_d   = (s_axi_arlen == 8'd0);
               rvalid_d  = 1'b1;
               arready_d = 1'b0;
               rstate_d  = R_DATA;
            end
         end
         R_DATA: begin
            if (rvalid_q && s_axi_rready) begin
               if (rlast_q) begin
                  rvalid_d  = 1'b0;
                  rlast_d   = 1'b0;
                  arready_d = 1'b1;
                  rstate_d  = R_IDLE;
               end else begin
                  ram_re  = 1'b1;
                  rword_d = rword_q + MW'(1);
                  rcnt_d  = rcnt_q + 8'd1;
                  rlast_d = (rcnt_q == rlen_q);
               end
            end
         end
         default: rstate_d = R_IDLE;
      endcase
   end

   // The burst error is carried by the latched response code.
   function automatic logic rerr_of_resp(input logic [1:0] resp);
      return resp == RESP_SLVERR;
   endfunction

   axi_slv_ram #(.DATA_WDTH(DATA_WDTH), .MEM_DPTH(MEM_DPTH)) u_ram (
      .clk     (axi_clk),
      .rst_n   (axi_rst_n),
      .we_i    (ram_we),
      .waddr_i (wword_q),
      .wstrb_i (s_axi_wstrb),
      .wdata_i (s_axi_wdata),
      .re_i    (ram_re),
      .rzero_i (ram_rzero),
      .raddr_i (ram_raddr),
      .rdata_o (s_axi_rdata)
   );

   assign s_axi_awready = awready_q;
   assign s_axi_wready  = wready_q;
   assign s_axi_bvalid  = bvalid_q;
   assign s_axi_bresp   = bresp_q;
   assign s_axi_bid     = bid_q;
   assign s_axi_arready = arready_q;
   assign s_axi_rvalid  = rvalid_q;
   assign s_axi_rlast   = rlast_q;
   assign s_axi_rresp   = rresp_q;
   assign s_axi_rid     = rid_q;

   logic unused_sideband;
   assign unused_sideband = ^{s_axi_awburst, s_axi_awsize, s_axi_awcache, s_axi_awlock, s_axi_awprot,
                              s_axi_awqos, s_axi_awuser, s_axi_arburst, s_axi_arsize, s_axi_arcache,
                              s_axi_arlock, s_axi_arprot, s_axi_arqos, s_axi_aruser};

`ifdef AXI_SLV_DBGCNT_EN
   logic [DGBCNT_WDTH-1:0] aw_cnt_q, ar_cnt_q, err_cnt_q;
   logic                   b_err, r_err;

   assign b_err = bvalid_q && s_axi_bready && (bresp_q == RESP_SLVERR);
   assign r_err = rvalid_q && s_axi_rready && rlast_q && (rresp_q == RESP_SLVERR);

   function automatic logic [DGBCNT_WDTH-1:0] sat_add(input logic [DGBCNT_WDTH-1:0] c,
                                                      input logic [1:0] inc);
      logic [DGBCNT_WDTH:0] s;
      s = {1'b0, c} + (DGBCNT_WDTH+1)'(inc);
      return s[DGBCNT_WDTH] ? '1 : s[DGBCNT_WDTH-1:0];
   endfunction

   // Saturating handshake/error counters; clear has priority over increment.
   always_ff @(posedge axi_clk or negedge axi_rst_n) begin
      if (!axi_rst_n) begin
         aw_cnt_q <= '0; ar_cnt_q <= '0; err_cnt_q <= '0;
      end else if (dbg_cnt_clr) begin
         aw_cnt_q <= '0; ar_cnt_q <= '0; err_cnt_q <= '0;
      end else begin
         aw_cnt_q  <= sat_add(aw_cnt_q,  {1'b0, s_axi_awvalid && awready_q});
         ar_cnt_q  <= sat_add(ar_cnt_q,  {1'b0, s_axi_arvalid && arready_q});
         err_cnt_q <= sat_add(err_cnt_q, 2'(b_err) + 2'(r_err));
      end
   end

   assign dbg_aw_cnt  = aw_cnt_q;
   assign dbg_ar_cnt  = ar_cnt_q;
   assign dbg_err_cnt = err_cnt_q;
`else
   logic unused_clr;
   assign unused_clr  = dbg_cnt_clr;
   assign dbg_aw_cnt  = '0;
   assign dbg_ar_cnt  = '0;
   assign dbg_err_cnt = '0;
`endif

endmodule
